// File: rtl/sample_decimator.sv
// Averages windows of 1/2/4/8 input samples into one output sample.
// Feeds wave_capture so the display can cover a longer time span.
module sample_decimator #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int MAX_LOG2     = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
  input  logic                    new_sample_ready,
  input  logic [1:0]              factor_sel,
  input  logic                    freeze,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic                    sample_out_ready,
  output logic [MAX_LOG2-1:0]     window_pos
);

  localparam int ACC_W = SAMPLE_WIDTH + MAX_LOG2;
  localparam logic [MAX_LOG2:0] ONE = 1;

  typedef enum logic {
    ACCUM,
    EMIT
  } state_t;

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  in_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  shifted;
  logic [1:0]               k_q;
  logic [1:0]               k_eff;
  logic [MAX_LOG2:0]        win_len;
  logic                     accept;
  logic                     last;

  // Window bookkeeping: the first sample of a window sees the new factor.
  always_comb begin
    accept  = new_sample_ready & ~freeze;
    k_eff   = (window_pos == '0) ? factor_sel : k_q;
    win_len = ONE << k_eff;
    last    = ({1'b0, window_pos} == (win_len - ONE));
    in_ext  = {{MAX_LOG2{new_sample_in[SAMPLE_WIDTH-1]}}, new_sample_in};
    sum     = acc + in_ext;
    shifted = sum >>> k_eff;
  end

  // Accumulate / emit FSM; EMIT still accepts so strobes can be continuous.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ACCUM;
      acc              <= '0;
      k_q              <= '0;
      window_pos       <= '0;
      sample_out       <= '0;
      sample_out_ready <= 1'b0;
    end else begin
      sample_out_ready <= 1'b0;
      if (state == EMIT) state <= ACCUM;
      if (accept) begin
        if (window_pos == '0) k_q <= factor_sel;
        if (last) begin
          sample_out       <= shifted[SAMPLE_WIDTH-1:0];
          acc              <= '0;
          window_pos       <= '0;
          state            <= EMIT;
          sample_out_ready <= 1'b1;
        end else begin
          acc        <= sum;
          window_pos <= window_pos + 1'b1;
        end
      end
    end
  end

endmodule
